// File: rtl/ch1_sweep_pkg.sv
// Shared APU definitions for the channel 1 frequency sweep unit.
package ch1_sweep_pkg;

  localparam int FREQ_W         = 11;
  localparam int PER_W          = 3;
  localparam int PERIOD_ZERO_AS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC1 = 2'd1,
    WRITE = 2'd2,
    CALC2 = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/ch1_sweep_calc.sv
// Combinational next-frequency datapath: shadow +/- (shadow >> shift) with overflow flag.
module ch1_sweep_calc #(
  parameter int FREQ_W = ch1_sweep_pkg::FREQ_W,
  parameter int PER_W  = ch1_sweep_pkg::PER_W
) (
  input  logic [FREQ_W-1:0] i_shadow,
  input  logic [PER_W-1:0]  i_shift,
  input  logic              i_negate,
  output logic [FREQ_W-1:0] o_sum,
  output logic              o_overflow
);

  logic [FREQ_W:0] w_delta;
  logic [FREQ_W:0] w_wide;

  // Subtraction cannot borrow because the delta never exceeds the shadow value.
  always_comb begin
    w_delta = {1'b0, i_shadow} >> i_shift;
    if (i_negate) begin
      w_wide = {1'b0, i_shadow} - w_delta;
    end else begin
      w_wide = {1'b0, i_shadow} + w_delta;
    end
  end

  assign o_sum      = w_wide[FREQ_W-1:0];
  assign o_overflow = w_wide[FREQ_W];

endmodule

// File: rtl/ch1_sweep.sv
// Channel 1 frequency sweep: shadow register, sweep timer and the IDLE/CALC1/WRITE/CALC2 sequencer.
module ch1_sweep #(
  parameter int FREQ_W = ch1_sweep_pkg::FREQ_W,
  parameter int PER_W  = ch1_sweep_pkg::PER_W
) (
  input  logic              dyfa_1mhz,
  input  logic              apu_reset,
  input  logic              sweep_tick,
  input  logic              ch1_restart,
  input  logic [PER_W-1:0]  nr10_period,
  input  logic              nr10_negate,
  input  logic [PER_W-1:0]  nr10_shift,
  input  logic [FREQ_W-1:0] freq_in,
  output logic [FREQ_W-1:0] acc_d,
  output logic              acc_load,
  output logic              ch1_sweep_off,
  output logic              sweep_busy
);

  import ch1_sweep_pkg::*;

  localparam int TMR_W = PER_W + 1;

  sweep_state_e      r_state,   w_stateNext;
  logic [FREQ_W-1:0] r_shadow,  w_shadowNext;
  logic [FREQ_W-1:0] r_sum,     w_sumNext;
  logic [FREQ_W-1:0] r_accD,    w_accDNext;
  logic [TMR_W-1:0]  r_timer,   w_timerNext;
  logic              r_accLoad, w_accLoadNext;
  logic              r_off,     w_offNext;
  logic              r_enable,  w_enableNext;
  logic              r_negUsed, w_negUsedNext;
  logic              r_negPrev;

  logic [FREQ_W-1:0] w_calcSum;
  logic              w_calcOvf;
  logic [TMR_W-1:0]  w_reload;
  logic              w_periodZero;
  logic              w_shiftZero;

  ch1_sweep_calc #(
    .FREQ_W (FREQ_W),
    .PER_W  (PER_W)
  ) u_calc (
    .i_shadow   (r_shadow),
    .i_shift    (nr10_shift),
    .i_negate   (nr10_negate),
    .o_sum      (w_calcSum),
    .o_overflow (w_calcOvf)
  );

  assign w_periodZero = (nr10_period == '0);
  assign w_shiftZero  = (nr10_shift == '0);
  assign w_reload     = w_periodZero ? TMR_W'(PERIOD_ZERO_AS) : {1'b0, nr10_period};

  always_ff @(posedge dyfa_1mhz or posedge apu_reset) begin
    if (apu_reset) begin
      r_state   <= IDLE;
      r_shadow  <= '0;
      r_sum     <= '0;
      r_accD    <= '0;
      r_timer   <= '0;
      r_accLoad <= 1'b0;
      r_off     <= 1'b0;
      r_enable  <= 1'b0;
      r_negUsed <= 1'b0;
      r_negPrev <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_shadow  <= w_shadowNext;
      r_sum     <= w_sumNext;
      r_accD    <= w_accDNext;
      r_timer   <= w_timerNext;
      r_accLoad <= w_accLoadNext;
      r_off     <= w_offNext;
      r_enable  <= w_enableNext;
      r_negUsed <= w_negUsedNext;
      r_negPrev <= nr10_negate;
    end
  end

  // A restart overrides everything, including a sweep already in flight.
  always_comb begin
    w_stateNext   = r_state;
    w_shadowNext  = r_shadow;
    w_sumNext     = r_sum;
    w_accDNext    = r_accD;
    w_timerNext   = r_timer;
    w_accLoadNext = 1'b0;
    w_offNext     = r_off;
    w_enableNext  = r_enable;
    w_negUsedNext = r_negUsed;

    if (ch1_restart) begin
      w_shadowNext  = freq_in;
      w_timerNext   = w_reload;
      w_enableNext  = !w_periodZero || !w_shiftZero;
      w_negUsedNext = 1'b0;
      w_offNext     = 1'b0;
      w_stateNext   = w_shiftZero ? IDLE : CALC2;
    end else begin
      if (r_negPrev && !nr10_negate && r_negUsed) begin
        w_offNext = 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (sweep_tick) begin
            if (r_timer > TMR_W'(1)) begin
              w_timerNext = r_timer - TMR_W'(1);
            end else begin
              w_timerNext = w_reload;
              if (r_enable && !w_periodZero) begin
                w_stateNext = CALC1;
              end
            end
          end
        end
        CALC1: begin
          if (nr10_negate) begin
            w_negUsedNext = 1'b1;
          end
          if (w_calcOvf) begin
            w_offNext   = 1'b1;
            w_stateNext = IDLE;
          end else if (!w_shiftZero) begin
            w_sumNext   = w_calcSum;
            w_stateNext = WRITE;
          end else begin
            w_stateNext = IDLE;
          end
        end
        WRITE: begin
          w_shadowNext  = r_sum;
          w_accDNext    = r_sum;
          w_accLoadNext = 1'b1;
          w_stateNext   = CALC2;
        end
        CALC2: begin
          if (nr10_negate) begin
            w_negUsedNext = 1'b1;
          end
          if (w_calcOvf) begin
            w_offNext = 1'b1;
          end
          w_stateNext = IDLE;
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  assign acc_d         = r_accD;
  assign acc_load      = r_accLoad;
  assign ch1_sweep_off = r_off;
  assign sweep_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_ch1_sweep.sv
// Directed bench for ch1_sweep: expected frequency writes are queued as stimulus is driven and matched on acc_load.
module tb_ch1_sweep;

  logic        dyfa_1mhz = 1'b0;
  logic        apu_reset;
  logic        sweep_tick;
  logic        ch1_restart;
  logic [2:0]  nr10_period;
  logic        nr10_negate;
  logic [2:0]  nr10_shift;
  logic [10:0] freq_in;
  logic [10:0] acc_d;
  logic        acc_load;
  logic        ch1_sweep_off;
  logic        sweep_busy;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [10:0] expQ[$];
  logic [10:0] expVal;

  ch1_sweep dut (
    .dyfa_1mhz     (dyfa_1mhz),
    .apu_reset     (apu_reset),
    .sweep_tick    (sweep_tick),
    .ch1_restart   (ch1_restart),
    .nr10_period   (nr10_period),
    .nr10_negate   (nr10_negate),
    .nr10_shift    (nr10_shift),
    .freq_in       (freq_in),
    .acc_d         (acc_d),
    .acc_load      (acc_load),
    .ch1_sweep_off (ch1_sweep_off),
    .sweep_busy    (sweep_busy)
  );

  always #5 dyfa_1mhz = ~dyfa_1mhz;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock with the given strobes high, returning at the following falling edge.
  task automatic applyStimulus(input logic doRestart, input logic doTick);
    ch1_restart = doRestart;
    sweep_tick  = doTick;
    @(negedge dyfa_1mhz);
    ch1_restart = 1'b0;
    sweep_tick  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge dyfa_1mhz);
  endtask

  task automatic setFields(input logic [10:0] f, input logic [2:0] p, input logic [2:0] s, input logic n);
    freq_in     = f;
    nr10_period = p;
    nr10_shift  = s;
    nr10_negate = n;
  endtask

  // Scoreboard side: every frequency write must match the oldest queued expectation.
  always @(negedge dyfa_1mhz) begin
    if (!apu_reset && acc_load === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_acc_load", 32'(acc_load), 32'd0);
      end else begin
        expVal = expQ.pop_front();
        checkOutput("acc_d_write", 32'(acc_d), 32'(expVal));
      end
    end
  end

  initial begin
    apu_reset   = 1'b1;
    sweep_tick  = 1'b0;
    ch1_restart = 1'b0;
    setFields(11'h000, 3'd0, 3'd0, 1'b0);
    waitCycles(2);
    checkOutput("reset_acc_d", 32'(acc_d), 32'd0);
    checkOutput("reset_acc_load", 32'(acc_load), 32'd0);
    checkOutput("reset_off", 32'(ch1_sweep_off), 32'd0);
    checkOutput("reset_busy", 32'(sweep_busy), 32'd0);
    apu_reset = 1'b0;

    // Ticks before any restart must never start a sweep.
    setFields(11'h400, 3'd1, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("pre_restart_busy", 32'(sweep_busy), 32'd0);
    end

    // Upward sweep, 0x400 -> 0x600, then CALC2 sees 0x900 overflow.
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_busy", 32'(sweep_busy), 32'd1);
    waitCycles(1);
    checkOutput("first_calc2_off", 32'(ch1_sweep_off), 32'd0);
    checkOutput("first_calc2_idle", 32'(sweep_busy), 32'd0);
    expQ.push_back(11'h600);
    applyStimulus(1'b0, 1'b1);
    checkOutput("lat_cycle1_load", 32'(acc_load), 32'd0);
    waitCycles(1);
    checkOutput("lat_cycle2_load", 32'(acc_load), 32'd0);
    waitCycles(1);
    checkOutput("lat_cycle3_load", 32'(acc_load), 32'd1);
    checkOutput("lat_cycle3_acc_d", 32'(acc_d), 32'h600);
    waitCycles(1);
    checkOutput("ovf_calc2_off", 32'(ch1_sweep_off), 32'd1);
    checkOutput("ovf_calc2_load", 32'(acc_load), 32'd0);
    applyStimulus(1'b0, 1'b1);
    waitCycles(4);
    checkOutput("off_sticky", 32'(ch1_sweep_off), 32'd1);

    // Restart near the top: overflow straight from the restart calculation.
    setFields(11'h7F0, 3'd1, 3'd1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_clears_off", 32'(ch1_sweep_off), 32'd0);
    waitCycles(1);
    checkOutput("restart_ovf_off", 32'(ch1_sweep_off), 32'd1);
    checkOutput("restart_ovf_load", 32'(acc_load), 32'd0);

    // Downward sweep with period 2: writes only on every second tick.
    setFields(11'h100, 3'd2, 3'd2, 1'b1);
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    for (int t = 1; t <= 4; t++) begin
      if (t == 2) expQ.push_back(11'h0C0);
      if (t == 4) expQ.push_back(11'h090);
      applyStimulus(1'b0, 1'b1);
      waitCycles(4);
    end
    checkOutput("neg_final_acc_d", 32'(acc_d), 32'h090);
    checkOutput("neg_sweep_off", 32'(ch1_sweep_off), 32'd0);
    checkOutput("neg_queue_drained", 32'(expQ.size()), 32'd0);

    // Clearing negate after a subtracting calculation kills the channel.
    setFields(11'h400, 3'd1, 3'd1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    expQ.push_back(11'h200);
    applyStimulus(1'b0, 1'b1);
    waitCycles(4);
    checkOutput("quirk_before_off", 32'(ch1_sweep_off), 32'd0);
    nr10_negate = 1'b0;
    waitCycles(1);
    checkOutput("quirk_off", 32'(ch1_sweep_off), 32'd1);
    setFields(11'h123, 3'd0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("quirk_restart_clears", 32'(ch1_sweep_off), 32'd0);
    waitCycles(2);
    checkOutput("quirk_stays_clear", 32'(ch1_sweep_off), 32'd0);

    // Period 0 disables tick-driven sweeps even with a nonzero shift.
    setFields(11'h200, 3'd0, 3'd3, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int t = 0; t < 16; t++) begin
      applyStimulus(1'b0, 1'b1);
      waitCycles(1);
    end
    checkOutput("period0_off", 32'(ch1_sweep_off), 32'd0);
    checkOutput("period0_busy", 32'(sweep_busy), 32'd0);

    // Restart landing on WRITE aborts the write.
    setFields(11'h100, 3'd1, 3'd1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1);
    waitCycles(1);
    checkOutput("abort_in_write", 32'(sweep_busy), 32'd1);
    nr10_shift = 3'd0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("abort_no_load", 32'(acc_load), 32'd0);
    checkOutput("abort_idle", 32'(sweep_busy), 32'd0);
    waitCycles(3);

    // Asynchronous reset in the middle of WRITE.
    setFields(11'h100, 3'd1, 3'd1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1);
    waitCycles(1);
    checkOutput("pre_reset_acc_d", 32'(acc_d), 32'h200);
    apu_reset = 1'b1;
    #1;
    checkOutput("async_acc_d", 32'(acc_d), 32'd0);
    checkOutput("async_acc_load", 32'(acc_load), 32'd0);
    checkOutput("async_busy", 32'(sweep_busy), 32'd0);
    checkOutput("async_off", 32'(ch1_sweep_off), 32'd0);
    waitCycles(2);
    apu_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      waitCycles(3);
    end
    checkOutput("post_reset_acc_d", 32'(acc_d), 32'd0);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ch1_sweep.md
CH1_SWEEP -- requirements
Module: ch1_sweep

Interface
REQ-001 Parameter FREQ_W, default 11, width of the channel 1 frequency and shadow register.
REQ-002 Parameter PER_W, default 3, width of the NR10 sweep period and shift fields.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port `dyfa_1mhz`, input, 1 bit: APU clock; all state changes on its rising edge.
REQ-005 Port `apu_reset`, input, 1 bit: asynchronous reset, active-high.
REQ-006 Port `sweep_tick`, input, 1 bit: one-cycle 128 Hz frame-sequencer strobe.
REQ-007 Port `ch1_restart`, input, 1 bit: one-cycle NR14 trigger strobe.
REQ-008 Port `nr10_period`, input, PER_W bits: sweep period, NR10[6:4].
REQ-009 Port `nr10_negate`, input, 1 bit: NR10[3]; 1 means subtract.
REQ-010 Port `nr10_shift`, input, PER_W bits: sweep shift, NR10[2:0].
REQ-011 Port `freq_in`, input, FREQ_W bits: NR14[2:0]:NR13 as currently held by the register block.
REQ-012 Port `acc_d`, output, FREQ_W bits: swept frequency driven to the frequency counter load inputs.
REQ-013 Port `acc_load`, output, 1 bit: one-cycle strobe; the counter and NR13/NR14 take `acc_d` on this cycle.
REQ-014 Port `ch1_sweep_off`, output, 1 bit: level; 1 disables channel 1 (overflow or negate quirk).
REQ-015 Port `sweep_busy`, output, 1 bit: high while the FSM is outside IDLE.

Function
REQ-016 Reset values SHALL be: shadow=0, timer=0, enable=0, neg_used=0, state=IDLE, acc_d=0, acc_load=0, ch1_sweep_off=0.
REQ-017 FSM states SHALL be IDLE, CALC1, WRITE, CALC2; each non-IDLE state SHALL last exactly one cycle.
REQ-018 Next-frequency calculation SHALL be sum = shadow ± (shadow >> nr10_shift), computed FREQ_W+1 bits wide; overflow means sum > 2^FREQ_W-1; subtraction never overflows.
REQ-019 Any calculation performed with nr10_negate=1 SHALL set neg_used.
REQ-020 On ch1_restart: shadow←freq_in; timer←nr10_period (0 treated as 8); enable←(period≠0 OR shift≠0); neg_used←0; ch1_sweep_off←0; then, if shift≠0, state←CALC2, else IDLE.
REQ-021 On sweep_tick in IDLE: if timer>1 then timer−1; else timer←period (0→8), and if enable=1 AND period≠0 then state←CALC1.
REQ-022 CALC1: on overflow, ch1_sweep_off←1 and →IDLE; else if shift≠0, latch sum and →WRITE; else →IDLE.
REQ-023 WRITE: shadow←sum, acc_d←sum, acc_load=1 for this cycle only, →CALC2.
REQ-024 CALC2: on overflow, ch1_sweep_off←1; the result SHALL NOT be written; →IDLE.
REQ-025 Latency: acc_load SHALL be asserted 2 cycles after the sweep_tick edge that starts CALC1.
REQ-026 When nr10_negate falls 1→0 while neg_used=1, ch1_sweep_off SHALL be set to 1 on the next clock.
REQ-027 ch1_restart SHALL take priority over sweep_tick and SHALL abort any in-progress CALC1/WRITE/CALC2 with no acc_load.
REQ-028 sweep_tick arriving while sweep_busy=1 SHALL be ignored.
REQ-029 ch1_sweep_off SHALL remain set until ch1_restart or reset.

Reset
REQ-030 apu_reset SHALL asynchronously force all REQ-016 values, regardless of clock.
REQ-031 After apu_reset deasserts, no acc_load SHALL occur before the first ch1_restart.

Structure
REQ-032 A shared APU package SHALL hold the FSM state enum, FREQ_W, PER_W, and the constant PERIOD_ZERO_AS = 8.
REQ-033 The shift/add/overflow datapath SHALL be one sub-module, ch1_sweep_calc, which is purely combinational and shared by CALC1 and CALC2.

Verification
REQ-034 Restart with freq_in=0x400, period=1, shift=1, negate=0, then one tick: acc_d=0x600 with acc_load after 2 cycles; CALC2 sees 0x900 > 0x7FF, so ch1_sweep_off=1.
REQ-035 Restart with freq_in=0x7F0, shift=1: ch1_sweep_off=1 within 1 cycle of restart, with no tick and no acc_load.
REQ-036 Restart with freq_in=0x100, period=2, shift=2, negate=1, then four ticks: acc_load on ticks 2 and 4 with acc_d=0x0C0 then 0x090.
REQ-037 Restart with period=0, shift=3, freq_in=0x200, then 16 ticks: no acc_load, and ch1_sweep_off stays 0.
REQ-038 Negate=1, one sweep calculation, then write negate=0: ch1_sweep_off=1 one cycle later; a following restart clears it.
REQ-039 Assert apu_reset during WRITE: outputs reach reset values immediately; acc_load=0.
